// File: rtl/riscv_send_desc_sched.sv
// Round-robin arbiter sharing the DMA send-descriptor port; one descriptor in flight at a time.
// Optional per-requester completion counters under `SEND_SCHED_STATS_EN.
module riscv_send_desc_sched #(
    parameter int unsigned REQ_COUNT  = 4,
    parameter int unsigned DESC_WIDTH = 64,
    parameter int unsigned REQ_WIDTH  = $clog2(REQ_COUNT)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [REQ_COUNT-1:0]            s_desc_valid,
    output logic [REQ_COUNT-1:0]            s_desc_ready,
    input  logic [REQ_COUNT*DESC_WIDTH-1:0] s_desc,
    output logic                            m_send_desc_valid,
    input  logic                            m_send_desc_ready,
    output logic [DESC_WIDTH-1:0]           m_send_desc,
    input  logic                            pkt_sent,
    output logic [REQ_COUNT-1:0]            req_done,
    output logic [REQ_WIDTH-1:0]            cur_grant,
    output logic                            busy,
    output logic                            err_spurious
`ifdef SEND_SCHED_STATS_EN
    ,
    input  logic [REQ_WIDTH-1:0]            stat_sel,
    output logic [31:0]                     stat_count
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [REQ_WIDTH-1:0]  last_grant_q, last_grant_d;
    logic [REQ_WIDTH-1:0]  cur_grant_q, cur_grant_d;
    logic [DESC_WIDTH-1:0] m_desc_q, m_desc_d;
    logic [REQ_COUNT-1:0]  req_done_q, req_done_d;
    logic                  err_q, err_d;

    logic [REQ_WIDTH-1:0]  pick;
    logic [DESC_WIDTH-1:0] pick_desc;
    logic                  found;
    int unsigned           idx;

    // Search starts just after the last completed owner and wraps around.
    always_comb begin
        pick      = '0;
        pick_desc = '0;
        found     = 1'b0;
        idx       = 0;
        for (int unsigned k = 1; k <= REQ_COUNT; k++) begin
            idx = 32'(last_grant_q) + k;
            if (idx >= REQ_COUNT) begin
                idx = idx - REQ_COUNT;
            end
            if (!found && s_desc_valid[REQ_WIDTH'(idx)]) begin
                found     = 1'b1;
                pick      = REQ_WIDTH'(idx);
                pick_desc = DESC_WIDTH'(s_desc >> (idx * DESC_WIDTH));
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cur_grant_d  = cur_grant_q;
        m_desc_d     = m_desc_q;
        req_done_d   = '0;
        s_desc_ready = '0;
        // Completion pulses outside WAIT (including the ISSUE handshake cycle) are flagged only.
        err_d        = err_q | (pkt_sent && (state_q != WAIT));
        case (state_q)
            IDLE: begin
                if (found) begin
                    s_desc_ready[pick] = 1'b1;
                    m_desc_d           = pick_desc;
                    cur_grant_d        = pick;
                    state_d            = ISSUE;
                end
            end
            ISSUE: begin
                if (m_send_desc_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (pkt_sent) begin
                    req_done_d[cur_grant_q] = 1'b1;
                    last_grant_d            = cur_grant_q;
                    state_d                 = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= REQ_WIDTH'(REQ_COUNT - 1);
            cur_grant_q  <= '0;
            m_desc_q     <= '0;
            req_done_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cur_grant_q  <= cur_grant_d;
            m_desc_q     <= m_desc_d;
            req_done_q   <= req_done_d;
            err_q        <= err_d;
        end
    end

    assign m_send_desc_valid = (state_q == ISSUE);
    assign busy              = (state_q != IDLE);
    assign m_send_desc       = m_desc_q;
    assign cur_grant         = cur_grant_q;
    assign req_done          = req_done_q;
    assign err_spurious      = err_q;

`ifdef SEND_SCHED_STATS_EN
    logic [31:0] cnt_q [REQ_COUNT];
    logic [31:0] stat_count_q;

    // Counters advance on the same edge that raises the completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < REQ_COUNT; i++) begin
                cnt_q[i] <= '0;
            end
            stat_count_q <= '0;
        end else begin
            for (int unsigned i = 0; i < REQ_COUNT; i++) begin
                if (req_done_d[i]) begin
                    cnt_q[i] <= cnt_q[i] + 32'd1;
                end
            end
            stat_count_q <= (32'(stat_sel) < REQ_COUNT) ? cnt_q[stat_sel] : '0;
        end
    end

    assign stat_count = stat_count_q;
`endif

endmodule

// File: tb/tb_riscv_send_desc_sched.sv
// Directed bench for riscv_send_desc_sched: arbitration order, stall, zero-length, spurious, reset.
module tb_riscv_send_desc_sched;

    localparam int unsigned RC = 4;
    localparam int unsigned DW = 64;

    logic           clk;
    logic           rst_n;
    logic [RC-1:0]  s_desc_valid;
    logic [RC-1:0]  s_desc_ready;
    logic [RC*DW-1:0] s_desc;
    logic           m_send_desc_valid;
    logic           m_send_desc_ready;
    logic [DW-1:0]  m_send_desc;
    logic           pkt_sent;
    logic [RC-1:0]  req_done;
    logic [1:0]     cur_grant;
    logic           busy;
    logic           err_spurious;
`ifdef SEND_SCHED_STATS_EN
    logic [1:0]     stat_sel;
    logic [31:0]    stat_count;
`endif

    logic [DW-1:0]  lane [RC];
    int             errors;
    int             checks;

    riscv_send_desc_sched #(.REQ_COUNT(RC), .DESC_WIDTH(DW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .s_desc_valid      (s_desc_valid),
        .s_desc_ready      (s_desc_ready),
        .s_desc            (s_desc),
        .m_send_desc_valid (m_send_desc_valid),
        .m_send_desc_ready (m_send_desc_ready),
        .m_send_desc       (m_send_desc),
        .pkt_sent          (pkt_sent),
        .req_done          (req_done),
        .cur_grant         (cur_grant),
        .busy              (busy),
        .err_spurious      (err_spurious)
`ifdef SEND_SCHED_STATS_EN
        ,
        .stat_sel          (stat_sel),
        .stat_count        (stat_count)
`endif
    );

    for (genvar g = 0; g < RC; g++) begin : g_lane
        assign s_desc[g*DW +: DW] = lane[g];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] mk_desc(input int i);
        return {32'hA000_0000 + 32'(i), 8'(i + 4), 8'(i + 8), 16'h0040 + 16'(i)};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        s_desc_valid = '0;
        pkt_sent = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Full IDLE->ISSUE->WAIT->IDLE round with DMA always ready; pkt_sent after wait_cyc WAIT cycles.
    task automatic run_round(input logic [3:0] mask, input int exp, input int wait_cyc);
        logic [3:0] oh;
        oh = 4'(1 << exp);
        s_desc_valid = mask;
        #1;
        check("ready_idle", 64'(s_desc_ready), 64'(oh));
        step();
        check("m_valid_issue", 64'(m_send_desc_valid), 64'd1);
        check("m_desc", m_send_desc, lane[exp]);
        check("cur_grant", 64'(cur_grant), 64'(exp));
        check("ready_issue", 64'(s_desc_ready), 64'd0);
        step();
        check("m_valid_wait", 64'(m_send_desc_valid), 64'd0);
        check("busy_wait", 64'(busy), 64'd1);
        repeat (wait_cyc) step();
        pkt_sent = 1'b1;
        step();
        pkt_sent = 1'b0;
        s_desc_valid = '0;
        check("req_done", 64'(req_done), 64'(oh));
        check("busy_done", 64'(busy), 64'd0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        s_desc_valid = '0;
        m_send_desc_ready = 1'b1;
        pkt_sent = 1'b0;
        for (int i = 0; i < RC; i++) lane[i] = mk_desc(i);
`ifdef SEND_SCHED_STATS_EN
        stat_sel = '0;
`endif
        #2;
        check("rst_m_valid", 64'(m_send_desc_valid), 64'd0);
        check("rst_m_desc", m_send_desc, 64'd0);
        check("rst_req_done", 64'(req_done), 64'd0);
        check("rst_grant", 64'(cur_grant), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err_spurious), 64'd0);
        check("rst_ready", 64'(s_desc_ready), 64'd0);
        do_reset();

        // Single requester 2, pkt_sent five cycles after accept.
        run_round(4'b0100, 2, 3);
        check("single_err", 64'(err_spurious), 64'd0);
        step();
        check("done_pulse_one", 64'(req_done), 64'd0);

        // All valid continuously from reset: 0,1,2,3,0,1.
        do_reset();
        for (int r = 0; r < 6; r++) run_round(4'b1111, r % 4, 1);

        // DMA stalls 10 cycles in ISSUE; last grant was 1 so 3 wins over 1.
        m_send_desc_ready = 1'b0;
        s_desc_valid = 4'b1010;
        #1;
        check("stall_pick", 64'(s_desc_ready), 64'b1000);
        step();
        for (int c = 0; c < 10; c++) begin
            check("stall_valid", 64'(m_send_desc_valid), 64'd1);
            check("stall_desc", m_send_desc, lane[3]);
            check("stall_ready", 64'(s_desc_ready), 64'd0);
            step();
        end
        m_send_desc_ready = 1'b1;
        step();
        check("stall_wait", 64'(m_send_desc_valid), 64'd0);
        pkt_sent = 1'b1;
        step();
        pkt_sent = 1'b0;
        s_desc_valid = '0;
        check("stall_done", 64'(req_done), 64'b1000);

        // Zero-length descriptor from requester 0, pkt_sent two cycles after accept.
        lane[0] = {32'hB000_0000, 8'h01, 8'h02, 16'h0000};
        run_round(4'b0001, 0, 0);
        check("zlen_grant", 64'(cur_grant), 64'd0);

        // Spurious completion while idle.
        pkt_sent = 1'b1;
        step();
        pkt_sent = 1'b0;
        check("spur_err", 64'(err_spurious), 64'd1);
        check("spur_busy", 64'(busy), 64'd0);
        check("spur_done", 64'(req_done), 64'd0);
        run_round(4'b0010, 1, 0);
        check("spur_sticky", 64'(err_spurious), 64'd1);

        // Reset in WAIT drops ownership; requester 0 wins afterwards.
        s_desc_valid = 4'b0001;
        step();
        s_desc_valid = '0;
        step();
        check("pre_rst_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_desc", m_send_desc, 64'd0);
        check("mid_rst_err", 64'(err_spurious), 64'd0);
        check("mid_rst_grant", 64'(cur_grant), 64'd0);
        step();
        check("mid_rst_done", 64'(req_done), 64'd0);
        rst_n = 1'b1;
        run_round(4'b1111, 0, 1);

`ifdef SEND_SCHED_STATS_EN
        do_reset();
        for (int r = 0; r < 3; r++) run_round(4'b0010, 1, 0);
        stat_sel = 2'd1;
        step();
        check("stat_req1", 64'(stat_count), 64'd3);
        stat_sel = 2'd0;
        step();
        check("stat_req0", 64'(stat_count), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
